// File: rtl/sdl_pkg.sv
// Shared definitions for the SYSROM UART loader.
// Holds the bit-period helper, default timing constants and the two FSM state
// encodings used by the receiver and by the SRAM write sequencer.
package sdl_pkg;

    localparam int WE_CYCLES_DEF      = 3;
    localparam int TIMEOUT_CYCLES_DEF = 24000000;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_SETUP,
        W_PULSE,
        W_HOLD
    } wr_state_t;

    // Clocks per UART bit, rounded to nearest.
    function automatic int bit_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/sysrom_uart_loader_if.sv
// SRAM write bus driven by the loader and muxed onto the SYSROM SRAM.
//   DEV_ADDR  : word address being written (also the word count shown on 7-seg)
//   DEV_DATA  : 16-bit write data
//   SRAM_WE_N : active-low write strobe
// master = loader side (drives), slave = SRAM / mux side (observes).
interface sysrom_uart_loader_if #(
    parameter int ADDR_W = 18
);
    logic [ADDR_W-1:0] DEV_ADDR;
    logic [15:0]       DEV_DATA;
    logic              SRAM_WE_N;

    modport master (output DEV_ADDR, output DEV_DATA, output SRAM_WE_N);
    modport slave  (input  DEV_ADDR, input  DEV_DATA, input  SRAM_WE_N);
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver, LSB first.
//   CLOCK_24        : system clock
//   nRESET          : synchronous, active-low reset
//   rx_en           : receiver enable; low forces the FSM back to IDLE
//   rxd             : asynchronous serial input, idle high
//   rx_byte         : received byte, valid while byte_valid is high
//   byte_valid      : 1-cycle pulse, good stop bit seen
//   frame_err_pulse : 1-cycle pulse, stop bit sampled low (byte discarded)
//   start_seen      : 1-cycle pulse on each falling edge detected in IDLE
module uart_rx_byte
    import sdl_pkg::*;
#(
    parameter int BIT_DIV = 208
) (
    input  logic       CLOCK_24,
    input  logic       nRESET,
    input  logic       rx_en,
    input  logic       rxd,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err_pulse,
    output logic       start_seen
);
    localparam int CNT_W = $clog2(BIT_DIV + 1);
    localparam logic [CNT_W-1:0] HALF_LD = CNT_W'(BIT_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LD = CNT_W'(BIT_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic            sync1_q, sync1_d, sync2_q, sync2_d;
    rx_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]      bits_q, bits_d;
    logic [7:0]      shift_q, shift_d;
    logic            expired;

    assign rx_byte = shift_q;
    assign expired = (cnt_q == '0);

    always_comb begin
        sync1_d         = rxd;
        sync2_d         = sync1_q;
        state_d         = state_q;
        cnt_d           = cnt_q;
        bits_d          = bits_q;
        shift_d         = shift_q;
        byte_valid      = 1'b0;
        frame_err_pulse = 1'b0;
        start_seen      = 1'b0;

        if (!rx_en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!sync2_q) begin
                        cnt_d      = HALF_LD;
                        state_d    = START;
                        start_seen = 1'b1;
                    end
                end
                START: begin
                    if (!expired) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end else if (sync2_q) begin
                        // line back high at mid start bit: noise, no byte
                        state_d = IDLE;
                    end else begin
                        cnt_d   = FULL_LD;
                        bits_d  = 3'd0;
                        state_d = DATA;
                    end
                end
                DATA: begin
                    if (!expired) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end else begin
                        shift_d = {sync2_q, shift_q[7:1]};
                        cnt_d   = FULL_LD;
                        if (bits_q == 3'd7) state_d = STOP;
                        else                bits_d  = bits_q + 3'd1;
                    end
                end
                STOP: begin
                    if (!expired) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end else if (sync2_q) begin
                        byte_valid = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        frame_err_pulse = 1'b1;
                        state_d         = BREAK;
                    end
                end
                BREAK: begin
                    if (sync2_q) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_24) begin
        if (!nRESET) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            bits_q  <= 3'd0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bits_q  <= bits_d;
        end
        shift_q <= shift_d;
    end

endmodule

// File: rtl/sysrom_uart_loader.sv
// SYSROM upload feeder: receives a raw image over 8N1 UART, packs byte pairs
// big-endian into 16-bit words and writes them to consecutive SRAM words.
//   CLOCK_24  : 24 MHz system clock
//   nRESET    : synchronous, active-low reset
//   UPLOAD_EN : 1 = upload mode; rising edge restarts the image
//   UART_RXD  : asynchronous serial input, idle high
//   sram      : DEV_ADDR / DEV_DATA / SRAM_WE_N write bus (master side)
//   FRAME_ERR : sticky, a stop bit was sampled low
//   LOADING   : a half word is held or a write is in progress
module sysrom_uart_loader
    import sdl_pkg::*;
#(
    parameter int CLK_HZ         = 24000000,
    parameter int BAUD           = 115200,
    parameter int ADDR_W         = 18,
    parameter int WE_CYCLES      = WE_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                         CLOCK_24,
    input  logic                         nRESET,
    input  logic                         UPLOAD_EN,
    input  logic                         UART_RXD,
    sysrom_uart_loader_if.master         sram,
    output logic                         FRAME_ERR,
    output logic                         LOADING
);
    localparam int BIT_DIV = bit_div(CLK_HZ, BAUD);
    localparam int TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int WE_W    = $clog2(WE_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYCLES);
    localparam logic [WE_W-1:0] WE_LAST = WE_W'(WE_CYCLES - 1);

    logic [7:0] rx_byte;
    logic       byte_valid, frame_err_pulse, start_seen;

    uart_rx_byte #(.BIT_DIV(BIT_DIV)) u_rx (
        .CLOCK_24        (CLOCK_24),
        .nRESET          (nRESET),
        .rx_en           (UPLOAD_EN),
        .rxd             (UART_RXD),
        .rx_byte         (rx_byte),
        .byte_valid      (byte_valid),
        .frame_err_pulse (frame_err_pulse),
        .start_seen      (start_seen)
    );

    logic              en_q, en_d;
    logic              phase_q, phase_d;
    logic [7:0]        hi_byte_q, hi_byte_d;
    wr_state_t         wstate_q, wstate_d;
    logic [WE_W-1:0]   we_cnt_q, we_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       data_q, data_d;
    logic              we_n_q, we_n_d;
    logic              ferr_q, ferr_d;
    logic [TO_W-1:0]   idle_q, idle_d;
    logic              rise, timeout, word_ready;

    assign rise    = UPLOAD_EN && !en_q;
    assign timeout = (idle_q == TO_MAX);

    assign sram.DEV_ADDR  = addr_q;
    assign sram.DEV_DATA  = data_q;
    assign sram.SRAM_WE_N = we_n_q;
    assign FRAME_ERR      = ferr_q;
    assign LOADING        = phase_q || (wstate_q != W_IDLE);

    always_comb begin
        en_d       = UPLOAD_EN;
        phase_d    = phase_q;
        hi_byte_d  = hi_byte_q;
        wstate_d   = wstate_q;
        we_cnt_d   = we_cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        we_n_d     = we_n_q;
        ferr_d     = ferr_q;
        idle_d     = idle_q;
        word_ready = 1'b0;

        if (rise || start_seen)  idle_d = '0;
        else if (!timeout)       idle_d = idle_q + TO_W'(1);

        // byte_valid takes priority over the idle restart
        if (byte_valid) begin
            if (!phase_q) begin
                hi_byte_d = rx_byte;
                phase_d   = 1'b1;
            end else begin
                phase_d    = 1'b0;
                word_ready = 1'b1;
            end
        end else if (timeout && wstate_q == W_IDLE) begin
            phase_d = 1'b0;
            addr_d  = '0;
        end

        if (frame_err_pulse) ferr_d = 1'b1;

        case (wstate_q)
            W_IDLE: begin
                if (word_ready) begin
                    data_d   = {hi_byte_q, rx_byte};
                    wstate_d = W_SETUP;
                end
            end
            W_SETUP: begin
                we_n_d   = 1'b0;
                we_cnt_d = '0;
                wstate_d = W_PULSE;
            end
            W_PULSE: begin
                if (we_cnt_q == WE_LAST) begin
                    we_n_d   = 1'b1;
                    wstate_d = W_HOLD;
                end else begin
                    we_cnt_d = we_cnt_q + WE_W'(1);
                end
            end
            W_HOLD: begin
                addr_d   = addr_q + ADDR_W'(1);
                wstate_d = W_IDLE;
            end
            default: wstate_d = W_IDLE;
        endcase

        // Upload off: abort any write, drop partial data, freeze the display.
        if (!UPLOAD_EN) begin
            wstate_d = W_IDLE;
            we_n_d   = 1'b1;
            phase_d  = 1'b0;
            addr_d   = addr_q;
            data_d   = data_q;
        end

        if (rise) begin
            addr_d  = '0;
            phase_d = 1'b0;
            ferr_d  = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_24) begin
        if (!nRESET) begin
            en_q     <= 1'b0;
            phase_q  <= 1'b0;
            wstate_q <= W_IDLE;
            we_cnt_q <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            we_n_q   <= 1'b1;
            ferr_q   <= 1'b0;
            idle_q   <= '0;
        end else begin
            en_q     <= en_d;
            phase_q  <= phase_d;
            wstate_q <= wstate_d;
            we_cnt_q <= we_cnt_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            we_n_q   <= we_n_d;
            ferr_q   <= ferr_d;
            idle_q   <= idle_d;
        end
        hi_byte_q <= hi_byte_d;
    end

endmodule

// File: tb/tb_sysrom_uart_loader.sv
// Testbench for sysrom_uart_loader: serial stimulus, behavioural word/address
// model and a per-cycle write-strobe checker.
module tb_sysrom_uart_loader;

    localparam int CLK_HZ    = 24000000;
    localparam int BAUD      = 1500000;
    localparam int ADDR_W    = 4;
    localparam int WE_CYC    = 3;
    localparam int TIMEOUT   = 1000;
    localparam int BIT_DIV   = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int ADDR_MOD  = 1 << ADDR_W;

    logic CLOCK_24  = 1'b0;
    logic nRESET    = 1'b0;
    logic UPLOAD_EN = 1'b0;
    logic UART_RXD  = 1'b1;
    logic FRAME_ERR, LOADING;

    sysrom_uart_loader_if #(.ADDR_W(ADDR_W)) sram ();

    sysrom_uart_loader #(
        .CLK_HZ         (CLK_HZ),
        .BAUD           (BAUD),
        .ADDR_W         (ADDR_W),
        .WE_CYCLES      (WE_CYC),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .CLOCK_24  (CLOCK_24),
        .nRESET    (nRESET),
        .UPLOAD_EN (UPLOAD_EN),
        .UART_RXD  (UART_RXD),
        .sram      (sram),
        .FRAME_ERR (FRAME_ERR),
        .LOADING   (LOADING)
    );

    always #10 CLOCK_24 = ~CLOCK_24;

    typedef struct {
        int addr;
        int data;
        bit aborted;
    } wr_t;

    wr_t exp_q[$];
    wr_t cmp_item;
    int  n_checks = 0;
    int  n_errors = 0;

    // behavioural model state
    int  m_addr  = 0;
    bit  m_phase = 0;
    int  m_hi    = 0;
    bit  m_ferr  = 0;

    bit  cmp_en    = 0;
    bit  abort_arm = 0;
    bit  abort_chk = 0;
    int  we_run    = 0;
    int  last_word = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock; also handles an armed mid-pulse upload abort.
    task automatic tick();
        @(posedge CLOCK_24);
        #1;
        if (abort_chk) begin
            check("abort_we_n", {31'd0, sram.SRAM_WE_N}, 1);
            check("abort_addr", {28'd0, sram.DEV_ADDR}, m_addr);
            abort_chk = 0;
        end else if (abort_arm && sram.SRAM_WE_N === 1'b0) begin
            UPLOAD_EN = 0;
            m_phase   = 0;
            abort_arm = 0;
            abort_chk = 1;
        end
    endtask

    task automatic model_byte(input logic [7:0] b, input bit ok, input bit abort);
        if (!ok) begin
            m_ferr = 1;
        end else if (!m_phase) begin
            m_hi    = b;
            m_phase = 1;
        end else begin
            last_word = (m_hi << 8) | b;
            exp_q.push_back('{addr: m_addr, data: last_word, aborted: abort});
            if (!abort) m_addr = (m_addr + 1) % ADDR_MOD;
            m_phase = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit ok, input bit abort, input int gap);
        UART_RXD = 1'b0;
        repeat (BIT_DIV) tick();
        for (int i = 0; i < 8; i++) begin
            UART_RXD = b[i];
            repeat (BIT_DIV) tick();
        end
        model_byte(b, ok, abort);
        if (abort) abort_arm = 1;
        UART_RXD = ok;
        repeat (BIT_DIV) tick();
        UART_RXD = 1'b1;
        repeat (12 + gap) tick();
        if (abort) check("abort_window", {31'd0, abort_arm}, 0);
        abort_arm = 0;
        check("loading", {31'd0, LOADING}, {31'd0, m_phase});
        check("frame_err", {31'd0, FRAME_ERR}, {31'd0, m_ferr});
    endtask

    // Write-strobe checker: every low cycle must match the expected write.
    always @(negedge CLOCK_24) begin
        if (cmp_en) begin
            if (sram.SRAM_WE_N === 1'b0) begin
                if (exp_q.size() == 0) begin
                    if (we_run == 0) check("unexpected_write", {28'd0, sram.DEV_ADDR}, 32'hFFFF_FFFF);
                end else begin
                    check("wr_addr", {28'd0, sram.DEV_ADDR}, exp_q[0].addr);
                    check("wr_data", {16'd0, sram.DEV_DATA}, exp_q[0].data);
                end
                we_run++;
            end else if (we_run > 0) begin
                if (exp_q.size() != 0) begin
                    cmp_item = exp_q.pop_front();
                    if (cmp_item.aborted)
                        check("we_abort_len", {31'd0, (we_run >= 1 && we_run < WE_CYC)}, 1);
                    else
                        check("we_len", we_run, WE_CYC);
                end
                we_run = 0;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [7:0] b;

        repeat (3) tick();
        check("rst_addr",    {28'd0, sram.DEV_ADDR}, 0);
        check("rst_data",    {16'd0, sram.DEV_DATA}, 0);
        check("rst_we_n",    {31'd0, sram.SRAM_WE_N}, 1);
        check("rst_ferr",    {31'd0, FRAME_ERR}, 0);
        check("rst_loading", {31'd0, LOADING}, 0);
        nRESET = 1'b1;
        tick();
        UPLOAD_EN = 1'b1;
        cmp_en    = 1;
        repeat (4) tick();

        // basic word
        send_byte(8'h12, 1, 0, 0);
        send_byte(8'h34, 1, 0, 0);
        check("t1_data", {16'd0, sram.DEV_DATA}, 32'h1234);
        check("t1_addr", {28'd0, sram.DEV_ADDR}, 1);

        // framing error leaves the phase alone
        send_byte(8'hA5, 0, 0, 5);
        send_byte(8'h56, 1, 0, 3);
        send_byte(8'h78, 1, 0, 0);
        check("t2_data", {16'd0, sram.DEV_DATA}, 32'h5678);
        check("t2_addr", {28'd0, sram.DEV_ADDR}, 2);
        check("t2_ferr", {31'd0, FRAME_ERR}, 1);

        // short low glitch: no byte
        UART_RXD = 1'b0;
        repeat (BIT_DIV / 4) tick();
        UART_RXD = 1'b1;
        repeat (BIT_DIV * 12) tick();
        check("t3_loading", {31'd0, LOADING}, 0);
        check("t3_addr", {28'd0, sram.DEV_ADDR}, 2);

        // idle timeout discards a half word and restarts the image
        send_byte(8'hAB, 1, 0, 0);
        repeat (TIMEOUT + 200) tick();
        m_phase = 0;
        m_addr  = 0;
        check("t4_loading", {31'd0, LOADING}, 0);
        check("t4_addr0", {28'd0, sram.DEV_ADDR}, 0);
        send_byte(8'h11, 1, 0, 2);
        send_byte(8'h22, 1, 0, 0);
        check("t4_data", {16'd0, sram.DEV_DATA}, 32'h1122);
        check("t4_addr", {28'd0, sram.DEV_ADDR}, 1);

        // 17 words into a 16-word space
        repeat (TIMEOUT + 200) tick();
        m_addr = 0;
        for (int i = 0; i < 17; i++) begin
            w = $urandom_range(0, 65535);
            b = w[15:8];
            send_byte(b, 1, 0, $urandom_range(0, 40));
            b = w[7:0];
            send_byte(b, 1, 0, $urandom_range(0, 40));
        end
        check("t5_addr", {28'd0, sram.DEV_ADDR}, 1);
        check("t5_data", {16'd0, sram.DEV_DATA}, last_word);

        // drop upload mode in the middle of the strobe
        send_byte(8'h9A, 1, 0, 0);
        send_byte(8'hBC, 1, 1, 0);
        check("t6_addr_held", {28'd0, sram.DEV_ADDR}, 1);
        check("t6_ferr_held", {31'd0, FRAME_ERR}, 1);
        repeat (20) tick();
        UPLOAD_EN = 1'b1;
        m_addr  = 0;
        m_phase = 0;
        m_ferr  = 0;
        repeat (3) tick();
        check("t6_addr0",   {28'd0, sram.DEV_ADDR}, 0);
        check("t6_ferr0",   {31'd0, FRAME_ERR}, 0);
        check("t6_loading", {31'd0, LOADING}, 0);
        check("t6_data",    {16'd0, sram.DEV_DATA}, 32'h9ABC);

        // random traffic with occasional framing errors
        for (int i = 0; i < 24; i++) begin
            b = 8'($urandom_range(0, 255));
            send_byte(b, ($urandom_range(0, 7) != 0), 0, $urandom_range(0, 40));
        end

        for (int i = 0; i < 50 && (exp_q.size() != 0 || we_run != 0); i++) tick();
        check("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
